// File: rtl/spi_tx_sched_pkg.sv
// Shared configuration for the SPI transmit scheduler: default sizes and FSM state type.
package spi_tx_sched_pkg;

  localparam int P_NUM_REQ_DEF     = 4;
  localparam int P_DATA_WIDTH_DEF  = 8;
  localparam int P_WDOG_CYCLES_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_rr_ptr,
// wrapping modulo P_NUM_REQ (works for non-power-of-two requester counts).
module spi_rr_pick #(
  parameter int P_NUM_REQ = 4,
  parameter int P_IW      = $clog2(P_NUM_REQ)
) (
  input  logic [P_NUM_REQ-1:0] i_req,
  input  logic [P_IW-1:0]      i_rr_ptr,
  output logic [P_IW-1:0]      o_winner,
  output logic [P_NUM_REQ-1:0] o_grant,
  output logic                 o_any
);

  // Scan offsets from farthest to nearest so the nearest request overwrites the rest.
  always_comb begin
    int              v_sum;
    logic [P_IW-1:0] v_sel;
    v_sum    = 0;
    v_sel    = '0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = P_NUM_REQ - 1; k >= 0; k--) begin
      v_sum    = int'(i_rr_ptr) + k;
      v_sel    = (v_sum >= P_NUM_REQ) ? P_IW'(v_sum - P_NUM_REQ) : P_IW'(v_sum);
      o_winner = i_req[v_sel] ? v_sel : o_winner;
      o_any    = o_any | i_req[v_sel];
    end
    o_grant = o_any ? (P_NUM_REQ'(1) << o_winner) : '0;
  end

endmodule

// File: rtl/spi_tx_sched.sv
// Round-robin scheduler sharing one SPI transmitter between P_NUM_REQ requesters.
// Optional watchdog (frame abort + wdog_err pulse) enabled by defining SPI_SCHED_WDOG_EN.
module spi_tx_sched
  import spi_tx_sched_pkg::*;
#(
  parameter int P_NUM_REQ     = P_NUM_REQ_DEF,
  parameter int P_DATA_WIDTH  = P_DATA_WIDTH_DEF,
  parameter int P_WDOG_CYCLES = P_WDOG_CYCLES_DEF
) (
  input  logic                              clk_100,
  input  logic                              a_rst,
  input  logic [P_NUM_REQ-1:0]              req_valid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] req_data,
  output logic [P_NUM_REQ-1:0]              req_ready,
  output logic [P_NUM_REQ-1:0]              req_done,
  output logic                              tx_valid,
  output logic [P_DATA_WIDTH-1:0]           tx_data,
  input  logic                              tx_ready,
  output logic [P_NUM_REQ-1:0]              cs_sel,
  output logic [$clog2(P_NUM_REQ)-1:0]      grant_idx,
  output logic                              busy
`ifdef SPI_SCHED_WDOG_EN
  ,
  output logic                              wdog_err
`endif
);

  localparam int LP_IW = $clog2(P_NUM_REQ);

  sched_state_t            r_state;
  logic [LP_IW-1:0]        r_rr_ptr;
  logic [LP_IW-1:0]        r_grant_idx;
  logic [P_DATA_WIDTH-1:0] r_hold;
  logic                    r_seen_low;
  logic                    r_tx_valid;
  logic                    r_busy;
  logic [P_NUM_REQ-1:0]    r_cs_sel;
  logic [P_NUM_REQ-1:0]    r_done;

  logic [LP_IW-1:0]        w_winner;
  logic [P_NUM_REQ-1:0]    w_grant;
  logic                    w_any;
  logic                    w_wdog_hit;
  logic [P_DATA_WIDTH-1:0] w_words [P_NUM_REQ];

  for (genvar g = 0; g < P_NUM_REQ; g++) begin : g_words
    assign w_words[g] = req_data[g*P_DATA_WIDTH +: P_DATA_WIDTH];
  end

  spi_rr_pick #(
    .P_NUM_REQ (P_NUM_REQ),
    .P_IW      (LP_IW)
  ) u_pick (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

`ifdef SPI_SCHED_WDOG_EN
  localparam int LP_WW = $clog2(P_WDOG_CYCLES) + 1;

  logic [LP_WW-1:0] r_wdog;
  logic             r_wdog_err;

  assign w_wdog_hit = (r_wdog == LP_WW'(P_WDOG_CYCLES - 1));
  assign wdog_err   = r_wdog_err;

  // Frame watchdog: counts only while a frame is outstanding, so entering ISSUE starts at 0.
  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      r_wdog     <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog     <= (r_state == ISSUE || r_state == BUSY) ? r_wdog + LP_WW'(1) : '0;
      r_wdog_err <= w_wdog_hit && (r_state == ISSUE || r_state == BUSY);
    end
  end
`else
  assign w_wdog_hit = 1'b0;
`endif

  // Accept strobe is only offered while idle, and never during reset.
  assign req_ready = (r_state == IDLE && !a_rst) ? w_grant : '0;
  assign req_done  = r_done;
  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_hold;
  assign cs_sel    = r_cs_sel;
  assign grant_idx = r_grant_idx;
  assign busy      = r_busy;

  // Scheduler FSM with registered outputs updated on each transition.
  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_hold      <= '0;
      r_seen_low  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_cs_sel    <= '0;
      r_done      <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_hold      <= w_words[w_winner];
            r_grant_idx <= w_winner;
            r_cs_sel    <= w_grant;
            r_tx_valid  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_wdog_hit) begin
            r_tx_valid <= 1'b0;
            r_cs_sel   <= '0;
            r_done     <= r_cs_sel;
            r_state    <= DONE;
          end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_seen_low <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          // The transmitter may still show ready right after the handshake; wait for a low first.
          if (w_wdog_hit || (r_seen_low && tx_ready)) begin
            r_cs_sel <= '0;
            r_done   <= r_cs_sel;
            r_state  <= DONE;
          end else if (!tx_ready) begin
            r_seen_low <= 1'b1;
          end
        end
        DONE: begin
          r_busy   <= 1'b0;
          r_rr_ptr <= (r_grant_idx == LP_IW'(P_NUM_REQ - 1)) ? '0 : r_grant_idx + LP_IW'(1);
          r_state  <= IDLE;
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_cs_sel   <= '0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule
